// File: rtl/mouse_shot_ctl.sv
// Trigger/shot-capture stage: turns a synchronised left-button level into single,
// clamped shot events with a valid/ready handshake, an ammo limit and a cooldown.
module mouse_shot_ctl #(
    parameter int unsigned COOLDOWN_CYCLES = 3_250_000,
    parameter int unsigned AMMO            = 3,
    parameter int unsigned X_MAX           = 799,
    parameter int unsigned Y_MAX           = 599
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] xpos_in,
    input  logic [9:0] ypos_in,
    input  logic       mouse_left_in,
    input  logic       reload_in,
    input  logic       shot_ready,
    output logic       shot_valid,
    output logic [9:0] shot_x,
    output logic [9:0] shot_y,
    output logic [2:0] ammo_out,
    output logic       armed_out
);

    localparam int unsigned CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [2:0]    AMMO_FULL = 3'(AMMO);
    localparam logic [9:0]    X_LIM     = 10'(X_MAX);
    localparam logic [9:0]    Y_LIM     = 10'(Y_MAX);

    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        ARMED        = 2'd1,
        PENDING      = 2'd2,
        COOLDOWN     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          btn_prev_q;
    logic [2:0]    ammo_q, ammo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    shot_x_q, shot_x_d;
    logic [9:0]    shot_y_q, shot_y_d;

    logic       rise;
    logic [2:0] ammo_eff;

    assign rise = mouse_left_in & ~btn_prev_q;
    // Refill happens before any consumption in the same cycle.
    assign ammo_eff = reload_in ? AMMO_FULL : ammo_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        ammo_d   = ammo_eff;
        cnt_d    = cnt_q;
        shot_x_d = shot_x_q;
        shot_y_d = shot_y_q;

        unique case (state_q)
            WAIT_RELEASE: begin
                if (!mouse_left_in) state_d = ARMED;
            end
            ARMED: begin
                if (rise) begin
                    if (ammo_eff != 3'd0) begin
                        shot_x_d = (xpos_in > X_LIM) ? X_LIM : xpos_in;
                        shot_y_d = (ypos_in > Y_LIM) ? Y_LIM : ypos_in;
                        ammo_d   = ammo_eff - 3'd1;
                        state_d  = PENDING;
                    end else begin
                        state_d = WAIT_RELEASE;
                    end
                end
            end
            PENDING: begin
                if (shot_ready) begin
                    cnt_d   = CNT_LOAD;
                    state_d = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = mouse_left_in ? WAIT_RELEASE : ARMED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = WAIT_RELEASE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= WAIT_RELEASE;
            btn_prev_q <= 1'b1;
            ammo_q     <= AMMO_FULL;
            cnt_q      <= '0;
            shot_x_q   <= '0;
            shot_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            btn_prev_q <= mouse_left_in;
            ammo_q     <= ammo_d;
            cnt_q      <= cnt_d;
            shot_x_q   <= shot_x_d;
            shot_y_q   <= shot_y_d;
        end
    end

    assign shot_valid = (state_q == PENDING);
    assign shot_x     = shot_x_q;
    assign shot_y     = shot_y_q;
    assign ammo_out   = ammo_q;
    assign armed_out  = (state_q == ARMED) && (ammo_q != 3'd0);

endmodule

// File: tb/tb_mouse_shot_ctl.sv
// Directed bench for mouse_shot_ctl: a vector table for shots, clamping, ammo and reload,
// then hand-written sequences for stall, cooldown presses, reset abort and held-through-reset.
module tb_mouse_shot_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] xpos_in, ypos_in;
    logic       mouse_left_in, reload_in, shot_ready;
    logic       shot_valid;
    logic [9:0] shot_x, shot_y;
    logic [2:0] ammo_out;
    logic       armed_out;

    int total = 0;
    int bad = 0;
    int transfers = 0;

    typedef struct {
        logic       rst_n;
        logic       btn;
        logic [9:0] x;
        logic [9:0] y;
        logic       reload;
        logic       ready;
        logic       exp_valid;
        logic [9:0] exp_x;
        logic [9:0] exp_y;
        logic [2:0] exp_ammo;
        logic       exp_armed;
    } vec_t;

    vec_t vecs[$];

    mouse_shot_ctl #(
        .COOLDOWN_CYCLES(4),
        .AMMO(3),
        .X_MAX(799),
        .Y_MAX(599)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .xpos_in(xpos_in),
        .ypos_in(ypos_in),
        .mouse_left_in(mouse_left_in),
        .reload_in(reload_in),
        .shot_ready(shot_ready),
        .shot_valid(shot_valid),
        .shot_x(shot_x),
        .shot_y(shot_y),
        .ammo_out(ammo_out),
        .armed_out(armed_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && shot_valid && shot_ready) transfers++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic b, input logic [9:0] x, input logic [9:0] y,
                         input logic rl, input logic rdy);
        rst_n = r; mouse_left_in = b; xpos_in = x; ypos_in = y; reload_in = rl; shot_ready = rdy;
    endtask

    task automatic add(input logic r, input logic b, input logic [9:0] x, input logic [9:0] y,
                       input logic rl, input logic rdy, input logic ev, input logic [9:0] ex,
                       input logic [9:0] ey, input logic [2:0] ea, input logic earm);
        vec_t v;
        v = '{r, b, x, y, rl, rdy, ev, ex, ey, ea, earm};
        vecs.push_back(v);
    endtask

    // One clean click from ARMED: press, transfer, three cooldown cycles, back to ARMED.
    task automatic add_click(input logic [9:0] x, input logic [9:0] y, input logic [9:0] ex,
                             input logic [9:0] ey, input logic [2:0] ea);
        add(1, 1, x, y, 0, 1, 1, ex, ey, ea, 0);
        add(1, 0, 0, 0, 0, 1, 0, ex, ey, ea, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 0, 1, 0, ex, ey, ea, 0);
        add(1, 0, 0, 0, 0, 1, 0, ex, ey, ea, ea != 3'd0);
    endtask

    initial begin
        int t0;
        drive(0, 0, 0, 0, 0, 0);

        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 3, 1);
        add_click(100, 200, 100, 200, 2);
        add_click(1023, 600, 799, 599, 1);
        add_click(0, 1023, 0, 599, 0);
        // dry fire with empty magazine, then reload
        add(1, 1, 5, 5, 0, 1, 0, 0, 599, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 599, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 599, 3, 1);
        add_click(799, 599, 799, 599, 2);
        add_click(3, 4, 3, 4, 1);
        add_click(512, 300, 512, 300, 0);
        // reload and firing edge in the same cycle with ammo=0
        add(1, 1, 800, 600, 1, 1, 1, 799, 599, 2, 0);
        add(1, 0, 0, 0, 0, 1, 0, 799, 599, 2, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].btn, vecs[i].x, vecs[i].y, vecs[i].reload, vecs[i].ready);
            tick();
            check($sformatf("row%0d valid", i), 32'(shot_valid), 32'(vecs[i].exp_valid));
            check($sformatf("row%0d x", i), 32'(shot_x), 32'(vecs[i].exp_x));
            check($sformatf("row%0d y", i), 32'(shot_y), 32'(vecs[i].exp_y));
            check($sformatf("row%0d ammo", i), 32'(ammo_out), 32'(vecs[i].exp_ammo));
            check($sformatf("row%0d armed", i), 32'(armed_out), 32'(vecs[i].exp_armed));
        end

        // Held button with consumer stall; coordinates keep changing.
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0); tick();
        check("stall armed", 32'(armed_out), 1);
        t0 = transfers;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 10'(10 + i), 10'(20 + i), 0, i >= 10);
            tick();
            check($sformatf("stall%0d valid", i), 32'(shot_valid), 32'(i < 10));
            check($sformatf("stall%0d x", i), 32'(shot_x), 10);
            check($sformatf("stall%0d y", i), 32'(shot_y), 20);
            check($sformatf("stall%0d armed", i), 32'(armed_out), 0);
        end
        check("stall shots", 32'(transfers - t0), 1);
        check("stall ammo", 32'(ammo_out), 2);
        drive(1, 0, 0, 0, 0, 1); tick();
        check("stall release armed", 32'(armed_out), 1);

        // Presses during cooldown are ignored; first fresh press after cooldown fires.
        drive(1, 1, 1, 2, 0, 1); tick();
        check("cd shot valid", 32'(shot_valid), 1);
        drive(1, 0, 0, 0, 0, 1); tick();
        check("cd transfer", 32'(shot_valid), 0);
        drive(1, 1, 9, 9, 0, 1); tick();
        check("cd press ignored", 32'(shot_valid), 0);
        drive(1, 0, 9, 9, 0, 1); tick();
        drive(1, 0, 9, 9, 0, 1); tick();
        check("cd still blocked", 32'(armed_out), 0);
        drive(1, 0, 9, 9, 0, 1); tick();
        check("cd rearmed", 32'(armed_out), 1);
        check("cd ammo", 32'(ammo_out), 1);
        drive(1, 1, 33, 44, 0, 0); tick();
        check("refire valid", 32'(shot_valid), 1);
        check("refire x", 32'(shot_x), 33);
        check("refire ammo", 32'(ammo_out), 0);

        // Reset while a shot is pending aborts it and refills ammo.
        drive(0, 0, 0, 0, 0, 0); tick();
        check("rst valid", 32'(shot_valid), 0);
        check("rst ammo", 32'(ammo_out), 3);
        check("rst armed", 32'(armed_out), 0);
        check("rst x", 32'(shot_x), 0);
        t0 = transfers;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 1); tick();
            check($sformatf("post rst%0d valid", i), 32'(shot_valid), 0);
        end
        check("post rst transfers", 32'(transfers - t0), 0);
        check("post rst ammo", 32'(ammo_out), 3);

        // Button held through reset must not fire until released and pressed again.
        drive(0, 1, 50, 60, 0, 0); tick();
        drive(1, 1, 50, 60, 0, 0); tick();
        check("held valid a", 32'(shot_valid), 0);
        check("held armed", 32'(armed_out), 0);
        drive(1, 1, 50, 60, 0, 0); tick();
        check("held valid b", 32'(shot_valid), 0);
        drive(1, 0, 50, 60, 0, 0); tick();
        check("released armed", 32'(armed_out), 1);
        drive(1, 1, 7, 8, 0, 0); tick();
        check("second press valid", 32'(shot_valid), 1);
        check("second press x", 32'(shot_x), 7);
        check("second press y", 32'(shot_y), 8);
        check("second press ammo", 32'(ammo_out), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
